// File: rtl/qam_demapper.sv
// qam_demapper: 802.11a hard-decision demapper; drops null/pilot bins, reports pilot signs per symbol.
// Latency 1 cycle; the output register holds while out_ready is low and in_ready drops, so no sample is lost.
module qam_demapper #(
  parameter int DW    = 13,
  parameter int TH16  = 1296,
  parameter int TH64A = 632,
  parameter int TH64B = 1264,
  parameter int TH64C = 1896
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_i,
  input  logic signed [DW-1:0] in_q,
  input  logic [2:0]           bpsc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           out_bits,
  output logic [2:0]           out_nbits,
  output logic                 out_last,
  output logic                 pilot_valid,
  output logic [3:0]           pilot_pol,
  output logic                 bpsc_err
);

  logic [5:0]    bin_cnt;
  logic [2:0]    bpsc_lat;
  logic [3:0]    shadow;
  logic          xfer;
  logic          is_null;
  logic          is_pilot;
  logic [1:0]    pidx;
  logic          i_pos;
  logic          q_pos;
  logic [DW-1:0] mag_i;
  logic [DW-1:0] mag_q;
  logic [5:0]    bits;
  logic          emit;

  function automatic logic legal(input logic [2:0] b);
    return (b == 3'd1) || (b == 3'd2) || (b == 3'd4) || (b == 3'd6);
  endfunction

  // |x| with the most negative code saturated to the largest positive one
  function automatic logic [DW-1:0] mag(input logic signed [DW-1:0] x);
    logic [DW-1:0] m;
    if (!x[DW-1])
      m = x;
    else if (x == {1'b1, {(DW-1){1'b0}}})
      m = {1'b0, {(DW-1){1'b1}}};
    else
      m = -x;
    return m;
  endfunction

  function automatic logic lt(input logic [DW-1:0] m, input int th);
    return int'({1'b0, m}) < th;
  endfunction

  assign in_ready = !rst && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    is_null  = (bin_cnt == 6'd0) || ((bin_cnt >= 6'd27) && (bin_cnt <= 6'd37));
    is_pilot = 1'b0;
    pidx     = 2'd0;
    case (bin_cnt)
      6'd7:    begin is_pilot = 1'b1; pidx = 2'd0; end
      6'd21:   begin is_pilot = 1'b1; pidx = 2'd1; end
      6'd43:   begin is_pilot = 1'b1; pidx = 2'd2; end
      6'd57:   begin is_pilot = 1'b1; pidx = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    i_pos = !in_i[DW-1];
    q_pos = !in_q[DW-1];
    mag_i = mag(in_i);
    mag_q = mag(in_q);
    bits  = 6'd0;
    case (bpsc_lat)
      3'd1: bits = {5'd0, i_pos};
      3'd2: bits = {4'd0, i_pos, q_pos};
      3'd4: bits = {2'd0, i_pos, lt(mag_i, TH16), q_pos, lt(mag_q, TH16)};
      3'd6: bits = {i_pos, lt(mag_i, TH64B), !lt(mag_i, TH64A) && lt(mag_i, TH64C),
                    q_pos, lt(mag_q, TH64B), !lt(mag_q, TH64A) && lt(mag_q, TH64C)};
      default: bits = 6'd0;
    endcase
  end

  // bpsc_err is sticky, so it keeps the output muted for every later symbol too
  assign emit = xfer && !is_null && !is_pilot && legal(bpsc_lat) && !bpsc_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt     <= 6'd0;
      bpsc_lat    <= 3'd0;
      shadow      <= 4'd0;
      out_valid   <= 1'b0;
      out_bits    <= 6'd0;
      out_nbits   <= 3'd0;
      out_last    <= 1'b0;
      pilot_valid <= 1'b0;
      pilot_pol   <= 4'd0;
      bpsc_err    <= 1'b0;
    end else begin
      pilot_valid <= 1'b0;
      if (xfer) begin
        bin_cnt <= bin_cnt + 6'd1;
        if (bin_cnt == 6'd0) begin
          bpsc_lat <= bpsc;
          if (!legal(bpsc))
            bpsc_err <= 1'b1;
        end
        if (is_pilot)
          shadow[pidx] <= i_pos;
        if (bin_cnt == 6'd63) begin
          pilot_pol   <= shadow;
          pilot_valid <= 1'b1;
        end
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_bits  <= bits;
        out_nbits <= bpsc_lat;
        out_last  <= (bin_cnt == 6'd63);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qam_demapper.sv
// Directed bench for qam_demapper: QPSK, 64-QAM sweep, pilots, backpressure, bad bpsc, mid-symbol reset.
module tb_qam_demapper;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [12:0] in_i;
  logic signed [12:0] in_q;
  logic [2:0]         bpsc;
  logic               out_valid;
  logic               out_ready;
  logic [5:0]         out_bits;
  logic [2:0]         out_nbits;
  logic               out_last;
  logic               pilot_valid;
  logic [3:0]         pilot_pol;
  logic               bpsc_err;

  int                 nchk = 0;
  int                 nerr = 0;
  int                 nout;
  int                 k;
  int                 d;
  logic [3:0]         exp_pol;
  logic [5:0]         code;
  logic [5:0]         last_exp;
  logic signed [12:0] vi;
  logic signed [12:0] vq;

  logic signed [12:0] p16_i [4] = '{13'sd1944, -13'sd648, 13'sd648, -13'sd1944};
  logic signed [12:0] p16_q [4] = '{13'sd648, -13'sd1944, -13'sd648, 13'sd1944};
  logic [5:0]         p16_b [4] = '{6'b001011, 6'b000100, 6'b001101, 6'b000010};

  always #5 clk = ~clk;

  qam_demapper dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_i(in_i), .in_q(in_q), .bpsc(bpsc),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_nbits(out_nbits), .out_last(out_last),
    .pilot_valid(pilot_valid), .pilot_pol(pilot_pol), .bpsc_err(bpsc_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_data(input int b);
    return !(b == 0 || (b >= 27 && b <= 37) || b == 7 || b == 21 || b == 43 || b == 57);
  endfunction

  // Gray-coded 64-QAM axis level for a 3-bit code, scale 316 per unit
  function automatic logic signed [12:0] lvl64(input logic [2:0] c);
    case (c)
      3'b000:  return -13'sd2212;
      3'b001:  return -13'sd1580;
      3'b011:  return -13'sd948;
      3'b010:  return -13'sd316;
      3'b110:  return 13'sd316;
      3'b111:  return 13'sd948;
      3'b101:  return 13'sd1580;
      default: return 13'sd2212;
    endcase
  endfunction

  task automatic xfer_bin(input int b, input logic signed [12:0] i, input logic signed [12:0] q,
                          input bit exp_out, input logic [5:0] exp_bits, input logic [2:0] exp_n);
    in_valid = 1'b1;
    in_i     = i;
    in_q     = q;
    @(posedge clk);
    #1;
    if (out_valid) nout++;
    chk($sformatf("out_valid@%0d", b), out_valid, exp_out);
    if (exp_out) begin
      chk($sformatf("out_bits@%0d", b), out_bits, exp_bits);
      chk($sformatf("out_nbits@%0d", b), out_nbits, exp_n);
      chk($sformatf("out_last@%0d", b), out_last, b == 63);
    end
    chk($sformatf("pilot_valid@%0d", b), pilot_valid, b == 63);
    if (b == 63) chk("pilot_pol", pilot_pol, exp_pol);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_i = '0; in_q = '0; bpsc = 3'd0; out_ready = 1'b1; exp_pol = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bits", out_bits, 0);
    chk("rst_out_nbits", out_nbits, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_pilot_valid", pilot_valid, 0);
    chk("rst_pilot_pol", pilot_pol, 0);
    chk("rst_bpsc_err", bpsc_err, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // QPSK, constant point
    bpsc = 3'd2; exp_pol = 4'b1111; nout = 0;
    for (int b = 0; b < 64; b++) xfer_bin(b, 13'sd1448, -13'sd1448, is_data(b), 6'b000010, 3'd2);
    chk("qpsk_count", nout, 48);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pilot_valid_once", pilot_valid, 0);
    chk("drain_out_valid", out_valid, 0);

    // 64-QAM sweep over two symbols, pilots +,-,+,-
    bpsc = 3'd6; exp_pol = 4'b0101; nout = 0; k = 0;
    for (int s = 0; s < 2; s++) begin
      for (int b = 0; b < 64; b++) begin
        if (b == 7 || b == 43) xfer_bin(b, 13'sd2048, 13'sd0, 0, 6'd0, 3'd0);
        else if (b == 21 || b == 57) xfer_bin(b, -13'sd2048, 13'sd0, 0, 6'd0, 3'd0);
        else if (!is_data(b)) xfer_bin(b, 13'sd0, 13'sd0, 0, 6'd0, 3'd0);
        else begin
          if (k == 64) begin code = 6'b111110; vi = 13'sd632; vq = 13'sd316; end
          else if (k == 65) begin code = 6'b110110; vi = 13'sd631; vq = 13'sd316; end
          else begin
            code = (k < 64) ? 6'(k) : 6'(k - 66);
            vi = lvl64(code[5:3]);
            vq = lvl64(code[2:0]);
          end
          xfer_bin(b, vi, vq, 1, code, 3'd6);
          k++;
        end
      end
    end
    chk("qam64_count", nout, 96);

    // 16-QAM with a 5-cycle output stall after bin 20
    bpsc = 3'd4; exp_pol = 4'b1111; nout = 0; d = 0; last_exp = 6'd0;
    for (int b = 0; b < 64; b++) begin
      if (is_data(b)) begin
        last_exp = p16_b[d % 4];
        xfer_bin(b, p16_i[d % 4], p16_q[d % 4], 1, last_exp, 3'd4);
        d++;
      end else begin
        xfer_bin(b, 13'sd1448, 13'sd0, 0, 6'd0, 3'd0);
      end
      if (b == 20) begin
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(posedge clk);
          #1;
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          chk("stall_out_bits", out_bits, last_exp);
        end
        out_ready = 1'b1;
      end
    end
    chk("bp_count", nout, 48);

    // Illegal bpsc on bin 0, changed mid-symbol; next symbol stays muted
    bpsc = 3'd3; nout = 0;
    for (int s = 0; s < 2; s++) begin
      for (int b = 0; b < 64; b++) begin
        if (s == 0 && b == 10) bpsc = 3'd4;
        xfer_bin(b, 13'sd1448, 13'sd1448, 0, 6'd0, 3'd0);
        if (s == 0 && b == 0) chk("bpsc_err_set", bpsc_err, 1);
      end
    end
    chk("bpsc_err_sticky", bpsc_err, 1);
    chk("err_count", nout, 0);

    // Reset at bin 30, then a full symbol aligned to bin 0
    bpsc = 3'd2;
    for (int b = 0; b < 30; b++) xfer_bin(b, 13'sd1448, -13'sd1448, 0, 6'd0, 3'd0);
    rst = 1'b1;
    #1;
    chk("rst30_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("rst30_out_valid", out_valid, 0);
    chk("rst30_out_bits", out_bits, 0);
    chk("rst30_out_nbits", out_nbits, 0);
    chk("rst30_out_last", out_last, 0);
    chk("rst30_pilot_valid", pilot_valid, 0);
    chk("rst30_pilot_pol", pilot_pol, 0);
    chk("rst30_bpsc_err", bpsc_err, 0);
    rst = 1'b0;
    exp_pol = 4'b1100; nout = 0;
    for (int b = 0; b < 64; b++) begin
      vi = ((b & 4) != 0) ? -13'sd1448 : 13'sd1448;
      vq = ((b & 1) != 0) ? -13'sd1448 : 13'sd1448;
      code = {4'd0, (b & 4) == 0, (b & 1) == 0};
      xfer_bin(b, vi, vq, is_data(b), code, 3'd2);
    end
    chk("post_rst_count", nout, 48);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
